alu_operand_sequencer: RTL and testbench

Front-end sequencing stage for the 8-bit ALU. It accepts operand A, operand B and an opcode as three beats on a single valid/ready byte bus, holds them in registers that drive the combinational ALU, and captures the ALU result and flags one cycle later. It then presents them downstream on a valid/ready handshake. It sits between the host/test bus and the ALU datapath and provides the registered boundary on both sides of the ALU.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/enreg.sv | 29 ++
 rtl/alu_operand_sequencer.sv | 106 ++++++++++
 tb/tb_alu_operand_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, sequencer state encoding and ALU opcodes.
// Rev 1.0
`default_nettype none

package alu_pkg;

  localparam int ALU_DATA_W = 8;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    EXEC    = 3'd3,
    HOLD    = 3'd4
  } seq_state_t;

  localparam logic [ALU_OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [ALU_OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [ALU_OP_W-1:0] OP_AND = 3'd2;
  localparam logic [ALU_OP_W-1:0] OP_OR  = 3'd3;
  localparam logic [ALU_OP_W-1:0] OP_XOR = 3'd4;
  localparam logic [ALU_OP_W-1:0] OP_SHL = 3'd5;
  localparam logic [ALU_OP_W-1:0] OP_SHR = 3'd6;
  localparam logic [ALU_OP_W-1:0] OP_PASS_A = 3'd7;

endpackage

`default_nettype wire

// File: rtl/enreg.sv
// enreg: W-bit register with async active-low reset, sync clear and load enable.
// Rev 1.0
`default_nettype none

module enreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a flush discards a coincident beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: loads A/B/opcode beats for the ALU and returns its result via valid/ready.
// Rev 1.0
`default_nettype none

module alu_operand_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int OP_W   = ALU_OP_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry,
  output logic              out_zero,
  output logic [7:0]        op_count
);

  seq_state_t state;
  seq_state_t state_next;

  logic              load_a;
  logic              load_b;
  logic              load_op;
  logic              capture;
  logic              xfer;
  logic [DATA_W+1:0] res_d;
  logic [DATA_W+1:0] res_q;

  assign in_ready  = (state == LOAD_A) || (state == LOAD_B) || (state == LOAD_OP);
  assign out_valid = (state == HOLD);

  assign load_a  = (state == LOAD_A)  && in_valid;
  assign load_b  = (state == LOAD_B)  && in_valid;
  assign load_op = (state == LOAD_OP) && in_valid;
  assign capture = (state == EXEC);
  assign xfer    = (state == HOLD) && out_ready && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= LOAD_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD_A:  if (in_valid)  state_next = LOAD_B;
      LOAD_B:  if (in_valid)  state_next = LOAD_OP;
      LOAD_OP: if (in_valid)  state_next = EXEC;
      EXEC:                   state_next = HOLD;
      HOLD:    if (out_ready) state_next = LOAD_A;
      default:                state_next = LOAD_A;
    endcase
    if (flush) begin
      state_next = LOAD_A;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= 8'd0;
    end else if (xfer) begin
      op_count <= op_count + 8'd1;
    end
  end

  enreg #(.W(DATA_W)) u_reg_a (
    .clk(clk), .reset_n(reset_n), .clr(flush), .en(load_a), .d(in_data), .q(alu_a)
  );

  enreg #(.W(DATA_W)) u_reg_b (
    .clk(clk), .reset_n(reset_n), .clr(flush), .en(load_b), .d(in_data), .q(alu_b)
  );

  enreg #(.W(OP_W)) u_reg_op (
    .clk(clk), .reset_n(reset_n), .clr(flush), .en(load_op), .d(in_data[OP_W-1:0]), .q(alu_op)
  );

  // Zero flag is derived locally from the result, packed above carry.
  assign res_d = {(alu_result == '0), alu_carry, alu_result};

  enreg #(.W(DATA_W+2)) u_reg_res (
    .clk(clk), .reset_n(reset_n), .clr(flush), .en(capture), .d(res_d), .q(res_q)
  );

  assign out_data  = res_q[DATA_W-1:0];
  assign out_carry = res_q[DATA_W];
  assign out_zero  = res_q[DATA_W+1];

endmodule

`default_nettype wire

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed checks of the operand sequencer with a stub ALU.
// Rev 1.0
`default_nettype none

module tb_alu_operand_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       flush = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_op;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       out_carry;
  logic       out_zero;
  logic [7:0] op_count;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stub ALU: op 0 = ADD, op 1 = SUB (borrow in carry), others = AND.
  logic [8:0] alu_full;
  always_comb begin
    alu_full = {1'b0, alu_a & alu_b};
    if (alu_op == 3'd0) alu_full = {1'b0, alu_a} + {1'b0, alu_b};
    else if (alu_op == 3'd1) alu_full = {1'b0, alu_a} - {1'b0, alu_b};
  end
  assign alu_result = alu_full[7:0];
  assign alu_carry  = alu_full[8];

  alu_operand_sequencer dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero),
    .op_count(op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("send_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] op, input logic [7:0] exp_d,
                        input logic exp_c, input logic exp_z, input logic [7:0] exp_cnt);
    send(a);
    send(b);
    send(op);
    check({tag, "_alu_a"}, alu_a, a);
    check({tag, "_alu_b"}, alu_b, b);
    check({tag, "_alu_op"}, alu_op, op[2:0]);
    check({tag, "_valid_exec"}, out_valid, 1'b0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, exp_d);
    check({tag, "_carry"}, out_carry, exp_c);
    check({tag, "_zero"}, out_zero, exp_z);
    check({tag, "_ready_hold"}, in_ready, 1'b0);
    @(negedge clk);
    check({tag, "_valid_done"}, out_valid, 1'b0);
    check({tag, "_count"}, op_count, exp_cnt);
    check({tag, "_ready_done"}, in_ready, 1'b1);
  endtask

  initial begin
    int last_cyc;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] s;

    // Reset values
    #12;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_alu_a", alu_a, 8'h00);
    check("rst_out_data", out_data, 8'h00);
    check("rst_op_count", op_count, 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    run_op("add1", 8'h3C, 8'h05, 8'h00, 8'h41, 1'b0, 1'b0, 8'd1);
    run_op("addz", 8'hFF, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 8'd2);
    run_op("sub", 8'h10, 8'h20, 8'hF9, 8'hF0, 1'b1, 1'b0, 8'd3);

    // Backpressure in HOLD with extra beats offered
    out_ready = 1'b0;
    send(8'h3C);
    send(8'h05);
    send(8'h00);
    @(negedge clk);
    check("bp_valid", out_valid, 1'b1);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int i = 0; i < 4; i++) begin
      check("bp_data", out_data, 8'h41);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_count", op_count, 8'd3);
      check("bp_valid_hold", out_valid, 1'b1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_done_valid", out_valid, 1'b0);
    check("bp_done_count", op_count, 8'd4);
    check("bp_alu_a_kept", alu_a, 8'h3C);
    check("bp_alu_b_kept", alu_b, 8'h05);

    // Flush in LOAD_OP with a coincident op beat
    send(8'h11);
    send(8'h22);
    in_valid = 1'b1;
    in_data  = 8'h01;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_in_ready", in_ready, 1'b1);
    check("fl_alu_a", alu_a, 8'h00);
    check("fl_alu_b", alu_b, 8'h00);
    check("fl_alu_op", alu_op, 3'd0);
    repeat (3) @(negedge clk);
    check("fl_no_valid", out_valid, 1'b0);
    check("fl_count", op_count, 8'd4);
    run_op("post_fl", 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b1, 8'd5);

    // Asynchronous reset mid-EXEC
    send(8'h01);
    send(8'h02);
    send(8'h00);
    #2 reset_n = 1'b0;
    #1;
    check("ar_valid", out_valid, 1'b0);
    check("ar_count", op_count, 8'd0);
    check("ar_alu_a", alu_a, 8'h00);
    check("ar_in_ready", in_ready, 1'b1);
    #1 reset_n = 1'b1;
    @(negedge clk);
    run_op("post_ar", 8'h21, 8'h12, 8'h00, 8'h33, 1'b0, 1'b0, 8'd1);

    // Clean start, then 256 back-to-back operations
    reset_n = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clk);
    last_cyc = 0;
    for (int i = 0; i < 256; i++) begin
      a = i[7:0];
      b = a ^ 8'h5A;
      s = a + b;
      send(a);
      send(b);
      send(8'h00);
      @(negedge clk);
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_data", out_data, s);
      if (i > 0) check("b2b_spacing", cyc - last_cyc, 32'd5);
      if (i == 255) check("b2b_count_255", op_count, 8'd255);
      last_cyc = cyc;
      @(negedge clk);
    end
    check("b2b_wrap", op_count, 8'd0);
    check("b2b_idle", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
